// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle MIPS ALU behind valid/ready handshakes.
// Single-cycle ops complete at the accept edge. sll runs one bit per cycle
// through a working register, so its latency is shamt+1 cycles.
module alu_exec_unit #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             branch_taken,
   output logic             jump_reg,
   output logic             illegal
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             br_q, br_d;
   logic             jr_q, jr_d;
   logic             ill_q, ill_d;

   // decoded values for the request currently on the input port
   logic [WIDTH-1:0] op_res;
   logic             op_br;
   logic             op_jr;
   logic             op_ill;
   logic             op_shift;
   logic             accept;

   assign in_ready     = (state_q == S_IDLE);
   assign out_valid    = (state_q == S_DONE);
   assign accept       = in_valid & in_ready;
   assign result       = result_q;
   assign zero         = zero_q;
   assign branch_taken = br_q;
   assign jump_reg     = jr_q;
   assign illegal      = ill_q;

   // Decode the control code into a single-cycle result and flags.
   always_comb begin
      op_res   = '0;
      op_br    = 1'b0;
      op_jr    = 1'b0;
      op_ill   = 1'b0;
      op_shift = 1'b0;
      case (alu_ctrl)
         4'b0010, 4'b0011, 4'b1000, 4'b1001: op_res = op_a + op_b;
         4'b0000, 4'b0001:                   op_res = op_a & op_b;
         4'b1100:                            op_res = ~(op_a | op_b);
         4'b0111: op_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         4'b1010: begin
            op_res = op_a - op_b;
            op_br  = (op_a == op_b);
         end
         4'b1111: begin
            op_res = op_a;
            op_jr  = 1'b1;
         end
         4'b1011: op_res   = op_a;
         4'b0100: op_shift = 1'b1;
         default: op_ill   = 1'b1;
      endcase
   end

   // Next-state logic for the IDLE/SHIFT/DONE sequencer and result registers.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      br_d     = br_q;
      jr_d     = jr_q;
      ill_d    = ill_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (op_shift) begin
                  // operands are captured here; later input changes are ignored
                  state_d = S_SHIFT;
                  shreg_d = op_b;
                  cnt_d   = shamt;
               end else begin
                  state_d  = S_DONE;
                  result_d = op_res;
                  zero_d   = (op_res == '0);
                  br_d     = op_br;
                  jr_d     = op_jr;
                  ill_d    = op_ill;
               end
            end
         end
         S_SHIFT: begin
            if (cnt_q == '0) begin
               state_d  = S_DONE;
               result_d = shreg_q;
               zero_d   = (shreg_q == '0);
            end else begin
               shreg_d = shreg_q << 1;
               cnt_d   = cnt_q - SHW'(1);
            end
         end
         S_DONE: begin
            // everything holds while the consumer stalls
            if (out_ready) begin
               state_d = S_IDLE;
               br_d    = 1'b0;
               jr_d    = 1'b0;
               ill_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset discards any in-flight operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         br_q     <= 1'b0;
         jr_q     <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         br_q     <= br_d;
         jr_q     <= jr_d;
         ill_q    <= ill_d;
      end
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Multi-cycle MIPS ALU that consumes the 4-bit ALU control code produced by the ALU control decoder. It executes the operation on 32-bit operands and returns the result with zero, branch and jump flags. Operands enter through a valid/ready handshake, and results leave through a second valid/ready handshake. Shifts run serially, one bit per cycle, so their latency depends on the operand.

Parameters:
WIDTH, 32, datapath width of operands and result
SHW, 5, shift-amount width (log2 WIDTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept a request
alu_ctrl  input  4  ALU control code
op_a  input  WIDTH  operand A (rs value, or link address for jal)
op_b  input  WIDTH  operand B (rt value or sign/zero-extended immediate)
shamt  input  SHW  shift amount for sll
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  operation result
zero  output  1  result == 0
branch_taken  output  1  beq and A == B
jump_reg  output  1  jr executed
illegal  output  1  unrecognised control code

Behaviour:
- Reset (asynchronous, any state): state=IDLE, in_ready=1, out_valid=0. result, zero, branch_taken, jump_reg and illegal all go to 0. Shift counter goes to 0. Any in-flight operation is discarded.
- FSM states: IDLE, SHIFT, DONE. in_ready=1 only in IDLE.
- Accept: in_valid & in_ready on a rising edge. alu_ctrl, op_a, op_b and shamt are registered at that edge. Later input changes are ignored until the next accept.
- Opcode map (all arithmetic is modulo 2^WIDTH with no overflow trap):
  - 0010 add, 0011 addi, 1000 lw, 1001 sw: result = A + B.
  - 0000 and, 0001 andi: result = A & B.
  - 1100 nor: result = ~(A | B).
  - 0111 slt: result = 1 if signed A < signed B, else 0.
  - 1010 beq: result = A - B; branch_taken = (A == B).
  - 1111 jr: result = A; jump_reg = 1.
  - 1011 jal: result = A (the link address).
  - 0100 sll: result = B << shamt, computed serially.
  - Any other code: result = 0, illegal = 1.
- zero = (result == 0) for every code, including illegal codes (zero=1 in that case).
- Non-shift ops: IDLE -> DONE at the accept edge. out_valid rises on the same edge, so latency is 1 cycle.
- sll:
  - IDLE -> SHIFT at the accept edge. The working register loads B and the counter loads shamt.
  - Each SHIFT cycle with counter != 0: register <<= 1, counter -= 1.
  - When counter == 0 in SHIFT: -> DONE.
  - Latency is shamt+1 cycles. shamt=0 gives result=B after 1 cycle; shamt=31 gives 32 cycles.
- DONE: all outputs hold stable while out_valid=1 and out_ready=0 (indefinite backpressure).
- On out_valid & out_ready: -> IDLE, out_valid=0 and flags cleared next cycle. Throughput is at most one op per 2 cycles.
- Flags branch_taken, jump_reg and illegal are meaningful only while out_valid=1, and are 0 otherwise.
- in_valid while busy: no accept. The requester must hold in_valid and its data until in_ready.

Test Plan:
- Reset mid-shift: accept sll with B=1, shamt=20, then assert reset at cycle 5 -> out_valid=0 and in_ready=1 immediately. The next add 2+3 gives result=5.
- Arithmetic: add 0xFFFFFFFF+1 -> result=0, zero=1, out_valid one cycle after accept. slt A=0xFFFFFFFF, B=1 -> result=1. nor 0,0 -> 0xFFFFFFFF.
- Branch/jump: beq A=B=7 -> result=0, zero=1, branch_taken=1. beq 7,8 -> branch_taken=0. jr A=0x400 -> result=0x400, jump_reg=1.
- Serial shift: sll B=0x3, shamt=4 -> result=0x30, out_valid exactly 5 cycles after accept. shamt=0 -> result=0x3 after 1 cycle. shamt=31 with B=1 -> 0x80000000 after 32 cycles.
- Backpressure: hold out_ready=0 for 10 cycles after an andi -> result and flags stable, in_ready=0, and a new in_valid is not accepted. Release -> in_ready=1 the next cycle.
- Illegal code 0101 -> result=0, illegal=1, zero=1. The following valid lw 0x100+0x4 gives 0x104 with illegal=0.
